// File: rtl/lsu.sv
// Load/store unit: decodes a memory access from the core's controls, runs
// one valid/ready transaction on the data-memory port while stalling the PC,
// and returns an extended, registered load result.
module lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        err_access,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d, to_q, to_d;

  logic        access, legal, misal, ok;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, shifted, ext;

  // Decode legality and alignment of the access presented in IDLE.
  always_comb begin
    access = MemRead | MemWrite;
    if (MemWrite) legal = (func3 == 3'b000) | (func3 == 3'b001) | (func3 == 3'b010);
    else          legal = (func3 == 3'b000) | (func3 == 3'b001) | (func3 == 3'b010) |
                          (func3 == 3'b100) | (func3 == 3'b101);
    misal = ((func3[1:0] == 2'b01) & addr[0]) |
            ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    ok    = legal & ~misal;
  end

  // Byte enables and lane-replicated write data; loads read the full word.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = store_data;
    if (MemWrite) begin
      case (func3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << addr[1:0];
          wdata_new = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_new    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{store_data[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = store_data;
        end
      endcase
    end
  end

  // Select the byte/halfword at the latched offset and extend it.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'b0, shifted[7:0]};
      3'b101:  ext = {16'b0, shifted[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  // Next-state logic: accept in IDLE, wait for ready or timeout in REQ,
  // and always fall back to IDLE from DONE so held controls cannot retrigger.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    ld_d    = ld_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access & ok) begin
          state_d = REQ;
          cnt_d   = 8'd0;
          off_d   = addr[1:0];
          f3_d    = func3;
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = wdata_new;
          be_d    = be_new;
          we_d    = MemWrite;
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (!we_q) ld_d = ext;
          state_d = DONE;
        end else if (cnt_q == LAST) begin
          if (!we_q) ld_d = 32'd0;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      ld_q    <= 32'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      to_q    <= to_d;
    end
  end

  assign mem_req     = (state_q == REQ);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign load_data   = ld_q;
  assign err_timeout = to_q;
  assign stall       = ~reset & (((state_q == IDLE) & access & ok) | (state_q == REQ));
  assign err_access  = ~reset & (state_q == IDLE) & access & ~ok;

endmodule

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
module tb_lsu;
  logic        clk = 1'b0, reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic        stall, err_access, err_timeout, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int total = 0, bad = 0;

  lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .func3(func3), .addr(addr), .store_data(store_data), .load_data(load_data),
    .stall(stall), .err_access(err_access), .err_timeout(err_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // Drives one instruction's controls and records what the port did.
  // Ready is raised on REQ cycle d (0-based); it is also high during the
  // accept cycle to show it is ignored outside REQ.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdat, input int d,
                        output int nst, output int nreq, output logic eacc,
                        output logic [31:0] oaddr, output logic [3:0] obe,
                        output logic [31:0] owd, output logic owe,
                        output logic oto, output logic [31:0] old,
                        output logic hung);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; func3 = f3; addr = a; store_data = sd;
    mem_rdata = rdat; mem_ready = 1'b1;
    #1;
    eacc = err_access; nst = int'(stall); nreq = int'(mem_req);
    oaddr = 32'd0; obe = 4'd0; owd = 32'd0; owe = 1'b0; oto = 1'b0; hung = 1'b0;
    old = load_data;
    if (!stall) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      nreq += int'(mem_req); nst += int'(stall); old = load_data;
    end else begin
      hung = 1'b1;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        mem_ready = (k == d);
        #1;
        if (mem_req) begin
          nreq++; oaddr = mem_addr; obe = mem_be; owd = mem_wdata; owe = mem_we;
        end
        if (stall) nst++;
        if (!stall && !mem_req) begin
          oto = err_timeout; old = load_data; hung = 1'b0;
          break;
        end
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic clear_ctrl();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; MemRead = 1'b1; func3 = 3'b010; addr = 32'h100; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    total++;
    if ({mem_req, mem_we, err_timeout, err_access, stall} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got %b want 00000", {mem_req, mem_we, err_timeout, err_access, stall});
    end
    total++;
    if ({mem_addr, mem_be, mem_wdata, load_data} !== 100'd0) begin
      bad++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_be, mem_wdata, load_data});
    end
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_load();
    int nst, nreq; logic ea, we, to, hg; logic [31:0] ad, wd, ld; logic [3:0] be;
    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({ad, be, we, ea, to, hg} !== {32'h100, 4'b1111, 4'b0000}) begin
      bad++; $display("FAIL lw_port got addr=%h be=%b we=%b ea=%b to=%b hung=%b want 100/1111/0/0/0/0", ad, be, we, ea, to, hg);
    end
    total++;
    if (nst !== 2 || nreq !== 1) begin
      bad++; $display("FAIL lw_timing got stall=%0d req=%0d want 2/1", nst, nreq);
    end
    total++;
    if (ld !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got %h want deadbeef", ld); end
  endtask

  task automatic test_load_ext();
    int nst, nreq; logic ea, we, to, hg; logic [31:0] ad, wd, ld; logic [3:0] be;
    access(1, 0, 3'b000, 32'h203, 0, 32'h80000000, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if (ld !== 32'hFFFFFF80 || ad !== 32'h200) begin bad++; $display("FAIL lb got %h addr %h want ffffff80/200", ld, ad); end
    access(1, 0, 3'b100, 32'h203, 0, 32'h80000000, 1, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if (ld !== 32'h00000080 || nst !== 3) begin bad++; $display("FAIL lbu got %h stall %0d want 00000080/3", ld, nst); end
    access(1, 0, 3'b101, 32'h202, 0, 32'h80011234, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if (ld !== 32'h00008001) begin bad++; $display("FAIL lhu got %h want 00008001", ld); end
    access(1, 0, 3'b001, 32'h202, 0, 32'h80011234, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if (ld !== 32'hFFFF8001) begin bad++; $display("FAIL lh got %h want ffff8001", ld); end
  endtask

  task automatic test_store();
    int nst, nreq; logic ea, we, to, hg; logic [31:0] ad, wd, ld; logic [3:0] be;
    access(0, 1, 3'b000, 32'h105, 32'h123456AB, 32'h0, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({ad, be, wd, we} !== {32'h104, 4'b0010, 32'hABABABAB, 1'b1}) begin
      bad++; $display("FAIL sb got %h %b %h %b want 104/0010/abababab/1", ad, be, wd, we);
    end
    total++;
    if (ld !== 32'hFFFF8001) begin bad++; $display("FAIL sb_ld_hold got %h want ffff8001", ld); end
    access(0, 1, 3'b001, 32'h106, 32'h123456AB, 32'h0, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({ad, be, wd} !== {32'h104, 4'b1100, 32'h56AB56AB}) begin
      bad++; $display("FAIL sh got %h %b %h want 104/1100/56ab56ab", ad, be, wd);
    end
    access(0, 1, 3'b010, 32'h10C, 32'hCAFE0001, 32'h0, 2, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({ad, be, wd, nst, nreq} !== {32'h10C, 4'b1111, 32'hCAFE0001, 32'd4, 32'd3}) begin
      bad++; $display("FAIL sw got %h %b %h st=%0d rq=%0d want 10c/1111/cafe0001/4/3", ad, be, wd, nst, nreq);
    end
  endtask

  task automatic test_errors();
    int nst, nreq; logic ea, we, to, hg; logic [31:0] ad, wd, ld; logic [3:0] be;
    access(1, 0, 3'b010, 32'h102, 0, 32'h11111111, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({ea, nst, nreq, ld} !== {1'b1, 32'd0, 32'd0, 32'hFFFF8001}) begin
      bad++; $display("FAIL lw_misaligned got ea=%b st=%0d rq=%0d ld=%h want 1/0/0/ffff8001", ea, nst, nreq, ld);
    end
    access(1, 0, 3'b011, 32'h100, 0, 32'h11111111, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({ea, nst, nreq} !== {1'b1, 32'd0, 32'd0}) begin
      bad++; $display("FAIL f3_011 got ea=%b st=%0d rq=%0d want 1/0/0", ea, nst, nreq);
    end
    access(0, 1, 3'b100, 32'h100, 0, 32'h0, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({ea, nst, nreq} !== {1'b1, 32'd0, 32'd0}) begin
      bad++; $display("FAIL store_f3_100 got ea=%b st=%0d rq=%0d want 1/0/0", ea, nst, nreq);
    end
  endtask

  task automatic test_both();
    int nst, nreq; logic ea, we, to, hg; logic [31:0] ad, wd, ld; logic [3:0] be;
    access(1, 1, 3'b010, 32'h400, 32'h0F0F0F0F, 32'h99999999, 0, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({we, wd, ld} !== {1'b1, 32'h0F0F0F0F, 32'hFFFF8001}) begin
      bad++; $display("FAIL both_rw got we=%b wd=%h ld=%h want 1/0f0f0f0f/ffff8001", we, wd, ld);
    end
  endtask

  task automatic test_timeout();
    int nst, nreq; logic ea, we, to, hg; logic [31:0] ad, wd, ld; logic [3:0] be;
    access(1, 0, 3'b010, 32'h500, 0, 32'h77777777, 99, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({to, hg, nreq, nst, ld} !== {1'b1, 1'b0, 32'd16, 32'd17, 32'd0}) begin
      bad++; $display("FAIL timeout got to=%b hung=%b rq=%0d st=%0d ld=%h want 1/0/16/17/0", to, hg, nreq, nst, ld);
    end
    access(1, 0, 3'b010, 32'h504, 0, 32'h0BADF00D, 15, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    total++;
    if ({to, nreq, ld} !== {1'b0, 32'd16, 32'h0BADF00D}) begin
      bad++; $display("FAIL ready_last got to=%b rq=%0d ld=%h want 0/16/0badf00d", to, nreq, ld);
    end
  endtask

  task automatic test_reset_mid();
    int nst, nreq; logic ea, we, to, hg; logic [31:0] ad, wd, ld; logic [3:0] be;
    // Park load_data at 0 first so "unchanged" and the reset value agree.
    access(1, 0, 3'b010, 32'h600, 0, 32'h0, 99, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
    @(negedge clk); MemRead = 1'b1; func3 = 3'b010; addr = 32'h300; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    @(negedge clk); reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
    total++;
    if ({mem_req, stall} !== 2'b10) begin bad++; $display("FAIL rst_mid_req3 got %b want 10", {mem_req, stall}); end
    @(negedge clk); reset = 1'b0; MemRead = 1'b0; mem_ready = 1'b0; #1;
    total++;
    if ({mem_req, stall, load_data} !== {2'b00, 32'd0}) begin
      bad++; $display("FAIL rst_mid got req=%b stall=%b ld=%h want 0/0/0", mem_req, stall, load_data);
    end
    @(negedge clk); #1;
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got req=%b want 0", mem_req); end
  endtask

  task automatic test_random();
    int nst, nreq, d, en_st, en_rq; logic ea, we, to, hg; logic [31:0] ad, wd, ld; logic [3:0] be;
    logic rd, wr, legal, aligned, e_to; logic [2:0] f3; logic [31:0] a, sd, rdat, v, e_ld, e_wd;
    logic [3:0] e_be; int sz, off;
    @(negedge clk); reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk); reset = 1'b0;
    e_ld = 32'd0;
    for (int i = 0; i < 60; i++) begin
      {wr, rd} = 2'($urandom_range(1, 3));
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 4) > 2) ? $urandom_range(4, 5) : $urandom_range(0, 2));
      a = $urandom; sd = $urandom; rdat = $urandom;
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
      sz = int'(f3 % 4); off = int'(a % 4);
      legal = wr ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
      aligned = (sz == 0) || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 0);
      e_to = (d >= 16);
      e_be = 4'b1111; e_wd = sd;
      if (wr && sz == 0) begin e_be = 4'(1 << off); e_wd = sd[7:0] * 32'h01010101; end
      if (wr && sz == 1) begin e_be = (off >= 2) ? 4'b1100 : 4'b0011; e_wd = sd[15:0] * 32'h00010001; end
      access(rd, wr, f3, a, sd, rdat, d, nst, nreq, ea, ad, be, wd, we, to, ld, hg);
      if (!(legal && aligned)) begin
        total++;
        if ({ea, nst, nreq, ld} !== {1'b1, 32'd0, 32'd0, e_ld}) begin
          bad++; $display("FAIL rand_err[%0d] f3=%0d a=%h got ea=%b st=%0d rq=%0d ld=%h want 1/0/0/%h", i, f3, a, ea, nst, nreq, ld, e_ld);
        end
        continue;
      end
      if (!wr) begin
        v = rdat >> (8 * off);
        if (e_to)           e_ld = 32'd0;
        else if (f3 == 3'd0) e_ld = (v % 256 >= 128) ? (v % 256) - 256 : v % 256;
        else if (f3 == 3'd1) e_ld = (v % 65536 >= 32768) ? (v % 65536) - 65536 : v % 65536;
        else if (f3 == 3'd4) e_ld = v % 256;
        else if (f3 == 3'd5) e_ld = v % 65536;
        else                e_ld = rdat;
      end
      en_rq = e_to ? 16 : d + 1; en_st = en_rq + 1;
      total++;
      if ({ea, hg, to, nst, nreq} !== {1'b0, 1'b0, e_to, en_st, en_rq}) begin
        bad++; $display("FAIL rand_timing[%0d] got ea=%b hung=%b to=%b st=%0d rq=%0d want 0/0/%b/%0d/%0d", i, ea, hg, to, nst, nreq, e_to, en_st, en_rq);
      end
      total++;
      if ({ad, be, we} !== {a & 32'hFFFFFFFC, e_be, wr} || (wr && wd !== e_wd)) begin
        bad++; $display("FAIL rand_port[%0d] got %h/%b/%b/%h want %h/%b/%b/%h", i, ad, be, we, wd, a & 32'hFFFFFFFC, e_be, wr, e_wd);
      end
      total++;
      if (ld !== e_ld) begin bad++; $display("FAIL rand_ld[%0d] f3=%0d got %h want %h", i, f3, ld, e_ld); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_ext();
    test_store();
    test_errors();
    test_both();
    test_timeout();
    test_reset_mid();
    test_random();
    clear_ctrl();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
